// File: rtl/encode_mux_pipe.sv
// Registered, flow-controlled binary-select lane mux with a saturating out-of-range counter.
// Define ENCODE_MUX_PIPE_SKID_EN for a main+skid buffer with a registered in_ready.
module encode_mux_pipe #(
    parameter int WIDTH         = 32,
    parameter int CNT           = 5,
    parameter int CNT_WIDTH     = 3,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH*CNT-1:0]     din,
    input  logic [CNT_WIDTH-1:0]     sel,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         dout,
    output logic                     sel_err,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt,
    input  logic                     err_clr
);

    // Handshake: a beat moves on a rising edge when valid & ready are both high;
    // a producer holds valid and its payload steady until that edge.

    logic [WIDTH-1:0] sel_data;
    logic             sel_bad;
    logic             in_xfer;
    logic             out_xfer;

    always_comb begin
        sel_data = '0;
        for (int k = 0; k < CNT; k++) begin
            if (sel == CNT_WIDTH'(k)) begin
                sel_data = din[k*WIDTH +: WIDTH];
            end
        end
    end

    // Widened by one bit so CNT == 2**CNT_WIDTH does not wrap the bound to zero.
    assign sel_bad  = ({1'b0, sel} >= (CNT_WIDTH+1)'(CNT));
    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (err_clr) begin
            err_cnt <= '0;
        end else if (in_xfer && sel_bad && (err_cnt != '1)) begin
            err_cnt <= err_cnt + ERR_CNT_WIDTH'(1);
        end
    end

`ifdef ENCODE_MUX_PIPE_SKID_EN
    logic             skid_valid;
    logic [WIDTH-1:0] skid_data;
    logic             skid_err;

    assign in_ready = !skid_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            dout       <= '0;
            sel_err    <= 1'b0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_err   <= 1'b0;
        end else if (!out_valid) begin
            if (in_xfer) begin
                out_valid <= 1'b1;
                dout      <= sel_bad ? '0 : sel_data;
                sel_err   <= sel_bad;
            end
        end else if (out_xfer) begin
            // Skid is older than any incoming beat, so it drains first.
            if (skid_valid) begin
                dout       <= skid_data;
                sel_err    <= skid_err;
                skid_valid <= 1'b0;
            end else if (in_xfer) begin
                dout    <= sel_bad ? '0 : sel_data;
                sel_err <= sel_bad;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (in_xfer) begin
            skid_valid <= 1'b1;
            skid_data  <= sel_bad ? '0 : sel_data;
            skid_err   <= sel_bad;
        end
    end
`else
    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            dout      <= '0;
            sel_err   <= 1'b0;
        end else if (in_xfer) begin
            out_valid <= 1'b1;
            dout      <= sel_bad ? '0 : sel_data;
            sel_err   <= sel_bad;
        end else if (out_xfer) begin
            out_valid <= 1'b0;
        end
    end
`endif

endmodule

// File: doc/encode_mux_pipe.md
# encode_mux_pipe

Registered, flow-controlled successor to the combinational encoded-select mux. It selects one of CNT WIDTH-bit lanes from a packed input bus using a binary select, and registers the result behind a valid/ready handshake. Out-of-range selects are flagged per beat and counted. It sits between register-file read sources and downstream consumers that may apply backpressure.

## Interface
- WIDTH, 32, bits per lane
- CNT, 5, number of lanes (≥2)
- CNT_WIDTH, 3, select width; must satisfy 2^CNT_WIDTH ≥ CNT
- ERR_CNT_WIDTH, 8, width of the saturating error counter
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat
- din  in  WIDTH*CNT  packed lanes; lane k = din[(k+1)*WIDTH-1 : k*WIDTH]
- sel  in  CNT_WIDTH  binary lane index, sampled with din
- out_valid  out  1  dout/sel_err hold a beat
- out_ready  in  1  downstream accepts beat
- dout  out  WIDTH  selected lane; all zeros when sel ≥ CNT
- sel_err  out  1  beat was produced from sel ≥ CNT
- err_cnt  out  ERR_CNT_WIDTH  saturating count of accepted beats with sel ≥ CNT
- err_clr  in  1  synchronous clear of err_cnt

## Operation
- Input transfer: in_valid & in_ready on a rising edge. Output transfer: out_valid & out_ready.
- Lane k is selected by exact compare sel == k over the full lane slice (correct bit range, not a partial slice).
- sel ≥ CNT: dout = 0, sel_err = 1 for that beat; err_cnt increments at the input transfer.
- err_cnt saturates at all-ones. err_clr and an erroring transfer in the same cycle: clear wins, err_cnt = 0.
- Output stage (main register): loads on input transfer when empty or when draining in the same cycle.
- Beats are never dropped, duplicated or reordered. dout/sel_err are stable while out_valid & !out_ready.
- Reset (async, any time incl. mid-transfer): out_valid = 0, dout = 0, sel_err = 0, err_cnt = 0, skid empty, in_ready = 1 once rst_n deasserts. Beats in flight are discarded.

## Timing
- Latency: a beat accepted at edge N is on dout with out_valid = 1 after edge N (visible in cycle N+1).
- Throughput: one beat per cycle while out_ready = 1.
- Without skid: in_ready = !out_valid | out_ready (combinational path out_ready → in_ready).
- With skid: in_ready is a flop output = skid empty; no combinational path from out_ready.
- Skid fill: input transfer while main full and !out_ready stores beat in skid; in_ready = 0 from next cycle.
- Skid drain: on output transfer with skid full, skid moves to main; in_ready = 1 next cycle.
- Simultaneous input and output transfer with main full, skid empty: new beat goes to main directly.

## Configuration
- ENCODE_MUX_PIPE_SKID_EN defined: 2-entry storage (main + skid), registered in_ready, full throughput with no ready combinational path.
- Not defined: single main register, in_ready combinational as above; identical data/error/latency behaviour otherwise.

## Test plan
- CNT=5, WIDTH=32, din lanes 0..4 = 0x1000_0000+k, sel 0..4 back-to-back, out_ready=1 → dout 0x1000_0000..0x1000_0004 in cycles 1..5, sel_err=0.
- sel=5,6,7 with out_ready=1 → dout=0, sel_err=1 each beat, err_cnt=3; then err_clr with sel=7 same cycle → err_cnt=0.
- ERR_CNT_WIDTH=2, five bad beats → err_cnt sticks at 3.
- Hold out_ready=0 for 4 cycles with in_valid=1, sel=2 (values A,B,C) → dout stays A; skid build: in_ready low after 2 accepts; release → A,B out in order, no loss; non-skid build: in_ready low after 1 accept.
- Random valid/ready toggling, 1000 beats, scoreboard → order and values match, dout stable while stalled.
- Assert rst_n low while skid full and out_valid=1 → out_valid, dout, sel_err, err_cnt drop to 0 immediately; first beat after release reappears one cycle after acceptance.
